// File: rtl/cmp_pkg.sv
// Shared comparison-alarm definitions: state encodings, run-counter width and
// small helpers used by the alarm FSM and by comparator-side benches.
package cmp_pkg;

    localparam int RUN_W = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMING   = 2'd1;
    localparam logic [1:0] ST_ALARM    = 2'd2;
    localparam logic [1:0] ST_CLEARING = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        ARMING   = ST_ARMING,
        ALARM    = ST_ALARM,
        CLEARING = ST_CLEARING
    } state_t;

    typedef logic [RUN_W-1:0] run_t;

    // True for exactly one set flag: XOR catches an odd count, the AND rules out three.
    function automatic logic is_one_hot(input logic l, input logic g, input logic e);
        return (l ^ g ^ e) && !(l && g && e);
    endfunction

    function automatic logic alarm_level(input state_t s);
        return (s == ALARM) || (s == CLEARING);
    endfunction

endpackage

// File: rtl/compare_alarm_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment loads 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/compare_alarm_fsm.sv
// Hysteresis alarm driven by one-hot comparator results: SET_CNT consecutive
// greaters raise the alarm, CLR_CNT consecutive lessers drop it.
module compare_alarm_fsm
    import cmp_pkg::*;
#(
    parameter int SET_CNT = 4,
    parameter int CLR_CNT = 3,
    parameter int EVW     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmp_valid,
    input  logic           lesser,
    input  logic           greater,
    input  logic           equal,
    input  logic           ev_clr,
    output logic           alarm,
    output logic           alarm_rise,
    output logic           alarm_fall,
    output logic [EVW-1:0] ev_count,
    output logic           err,
    output logic [1:0]     state
);

    localparam run_t SET_LAST = run_t'(SET_CNT - 1);
    localparam run_t CLR_LAST = run_t'(CLR_CNT - 1);

    state_t state_q;
    state_t state_d;
    run_t   run_q;
    run_t   run_d;
    logic   accept;
    logic   malformed;
    logic   ev_inc;
    logic   alarm_d;

    always_comb begin
        accept    = cmp_valid && is_one_hot(lesser, greater, equal);
        malformed = cmp_valid && !is_one_hot(lesser, greater, equal);
        state_d   = state_q;
        run_d     = run_q;
        ev_inc    = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (greater) begin
                        state_d = ARMING;
                        run_d   = run_t'(1);
                    end else begin
                        run_d   = '0;
                    end
                end
                ARMING: begin
                    // The sample that completes the run is the one that enters ALARM.
                    if (greater) begin
                        if (run_q == SET_LAST) begin
                            state_d = ALARM;
                            run_d   = '0;
                            ev_inc  = 1'b1;
                        end else begin
                            run_d   = run_q + run_t'(1);
                        end
                    end else if (lesser) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                ALARM: begin
                    if (lesser) begin
                        state_d = CLEARING;
                        run_d   = run_t'(1);
                    end
                end
                CLEARING: begin
                    if (lesser) begin
                        if (run_q == CLR_LAST) begin
                            state_d = IDLE;
                            run_d   = '0;
                        end else begin
                            run_d   = run_q + run_t'(1);
                        end
                    end else if (greater) begin
                        state_d = ALARM;
                        run_d   = '0;
                    end
                end
            endcase
        end

        alarm_d = alarm_level(state_d);
    end

    // Alarm and its edge pulses are registered alongside the state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            run_q      <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            alarm_fall <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            alarm      <= alarm_d;
            alarm_rise <= alarm_d && !alarm;
            alarm_fall <= !alarm_d && alarm;
            if (malformed) begin
                err <= 1'b1;
            end else if (ev_clr) begin
                err <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W (EVW)
    ) u_ev_counter (
        .clk (clk),
        .rst (rst),
        .clr (ev_clr),
        .inc (ev_inc),
        .q   (ev_count)
    );

    assign state = state_q;

endmodule

// File: tb/tb_compare_alarm_fsm.sv
// Scoreboard bench for compare_alarm_fsm: a reference model queues expected
// outputs per driven sample, which are popped and compared after the clock edge.
module tb_compare_alarm_fsm;

    localparam int SET_CNT = 4;
    localparam int CLR_CNT = 3;
    localparam int EVW     = 2;
    localparam int EV_MAX  = (1 << EVW) - 1;

    localparam logic [2:0] L = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] E = 3'b001;

    typedef struct {
        int st;
        int al;
        int ri;
        int fa;
        int ev;
        int er;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmp_valid = 1'b0;
    logic           lesser = 1'b0;
    logic           greater = 1'b0;
    logic           equal = 1'b0;
    logic           ev_clr = 1'b0;
    logic           alarm;
    logic           alarm_rise;
    logic           alarm_fall;
    logic [EVW-1:0] ev_count;
    logic           err;
    logic [1:0]     state;

    int   checkCount = 0;
    int   passCount  = 0;
    exp_t expQ[$];

    int mState = 0;
    int mRun   = 0;
    int mAlarm = 0;
    int mRise  = 0;
    int mFall  = 0;
    int mEv    = 0;
    int mErr   = 0;

    compare_alarm_fsm #(
        .SET_CNT (SET_CNT),
        .CLR_CNT (CLR_CNT),
        .EVW     (EVW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmp_valid  (cmp_valid),
        .lesser     (lesser),
        .greater    (greater),
        .equal      (equal),
        .ev_clr     (ev_clr),
        .alarm      (alarm),
        .alarm_rise (alarm_rise),
        .alarm_fall (alarm_fall),
        .ev_count   (ev_count),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference behaviour for one clock with the given inputs.
    task automatic modelStep(input logic v, input logic [2:0] leg, input logic clr);
        int ones;
        int inc;
        int prevAlarm;
        ones      = int'(leg[2]) + int'(leg[1]) + int'(leg[0]);
        inc       = 0;
        prevAlarm = mAlarm;
        if (v && ones == 1) begin
            case (mState)
                0: begin
                    if (leg == G) begin mState = 1; mRun = 1; end
                    else mRun = 0;
                end
                1: begin
                    if (leg == G) begin
                        if (mRun + 1 == SET_CNT) begin mState = 2; mRun = 0; inc = 1; end
                        else mRun++;
                    end else if (leg == L) begin
                        mState = 0; mRun = 0;
                    end
                end
                2: begin
                    if (leg == L) begin mState = 3; mRun = 1; end
                end
                default: begin
                    if (leg == L) begin
                        if (mRun + 1 == CLR_CNT) begin mState = 0; mRun = 0; end
                        else mRun++;
                    end else if (leg == G) begin
                        mState = 2; mRun = 0;
                    end
                end
            endcase
        end
        if (clr) mEv = inc;
        else if (inc == 1 && mEv < EV_MAX) mEv++;
        if (v && ones != 1) mErr = 1;
        else if (clr) mErr = 0;
        mAlarm = (mState >= 2) ? 1 : 0;
        mRise  = (mAlarm == 1 && prevAlarm == 0) ? 1 : 0;
        mFall  = (mAlarm == 0 && prevAlarm == 1) ? 1 : 0;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] leg, input logic clr,
                                 input string tag);
        exp_t e;
        @(negedge clk);
        cmp_valid = v;
        {lesser, greater, equal} = leg;
        ev_clr = clr;
        modelStep(v, leg, clr);
        expQ.push_back('{mState, mAlarm, mRise, mFall, mEv, mErr});
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput({tag, ".state"}, int'(state), e.st);
        checkOutput({tag, ".alarm"}, int'(alarm), e.al);
        checkOutput({tag, ".rise"}, int'(alarm_rise), e.ri);
        checkOutput({tag, ".fall"}, int'(alarm_fall), e.fa);
        checkOutput({tag, ".ev"}, int'(ev_count), e.ev);
        checkOutput({tag, ".err"}, int'(err), e.er);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".state"}, int'(state), 0);
        checkOutput({tag, ".alarm"}, int'(alarm), 0);
        checkOutput({tag, ".rise"}, int'(alarm_rise), 0);
        checkOutput({tag, ".fall"}, int'(alarm_fall), 0);
        checkOutput({tag, ".ev"}, int'(ev_count), 0);
        checkOutput({tag, ".err"}, int'(err), 0);
    endtask

    // Assert reset between edges, check outputs clear at once, then release.
    task automatic applyReset(input string tag);
        @(negedge clk);
        cmp_valid = 1'b0;
        ev_clr    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkAllZero(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mState = 0; mRun = 0; mAlarm = 0; mRise = 0; mFall = 0; mEv = 0; mErr = 0;
    endtask

    task automatic runSamples(input logic [2:0] leg, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, leg, 1'b0, tag);
    endtask

    initial begin
        logic [2:0] leg;
        logic       v;
        logic       clr;

        applyReset("reset");

        runSamples(G, 4, "set4");
        applyStimulus(1'b0, 3'b000, 1'b0, "hold");

        runSamples(L, 2, "clr2");
        applyStimulus(1'b1, G, 1'b0, "clrAbort");
        runSamples(L, 3, "clr3");
        applyStimulus(1'b0, 3'b000, 1'b0, "afterFall");

        runSamples(G, 2, "ggeg");
        applyStimulus(1'b1, E, 1'b0, "ggeg");
        runSamples(G, 2, "ggeg");
        runSamples(L, 3, "drop");
        runSamples(G, 2, "ggl");
        applyStimulus(1'b1, L, 1'b0, "ggl");

        runSamples(G, 2, "errPre");
        applyStimulus(1'b1, 3'b110, 1'b0, "errGL");
        applyStimulus(1'b1, 3'b000, 1'b0, "errNone");
        applyStimulus(1'b0, 3'b000, 1'b1, "errClr");
        applyStimulus(1'b1, 3'b111, 1'b1, "errClrColl");
        applyStimulus(1'b0, 3'b000, 1'b1, "errClr2");
        runSamples(L, 1, "errPost");

        for (int c = 0; c < 5; c++) begin
            runSamples(G, 4, "satSet");
            runSamples(L, 3, "satClr");
        end
        runSamples(G, 3, "clrRise");
        applyStimulus(1'b1, G, 1'b1, "clrRise");
        runSamples(L, 3, "clrRiseDrop");

        runSamples(G, 4, "rstPre");
        runSamples(L, 1, "rstPre");
        applyReset("rstMid");
        runSamples(G, 4, "rstPost");
        runSamples(L, 3, "rstPost");

        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2: leg = L;
                3, 4, 5, 6: leg = G;
                7, 8: leg = E;
                default: leg = 3'($urandom_range(0, 7));
            endcase
            clr = ($urandom_range(0, 15) == 0);
            applyStimulus(v, leg, clr, "rand");
        end

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
